coin_accept_q: RTL and testbench

//  Parametrised coin acceptor, successor to the single-coin inserter. Detects coin pulses on a
//  NUM_COINS one-hot input, maps each to its value, buffers values in a FIFO, and presents them

---
 rtl/coin_accept_q.sv | 239 +++++++++++++++++++++++
 tb/tb_coin_accept_q.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_accept_q.sv
// coin_accept_q: multi-denomination coin acceptor.
// Rising edges on the one-hot coin_in lines are mapped to coin values, buffered in a
// small FIFO and handed downstream one at a time over a valid/ready handshake. Each
// completed transfer is followed by a one-cycle done pulse.
// Optional feature macro: COIN_TOTAL_EN adds total_clr/credit_total and a saturating
// running-credit accumulator.
module coin_accept_q #(
    parameter int unsigned NUM_COINS  = 4,
    parameter int unsigned DATA_W     = 8,
    parameter logic [NUM_COINS*DATA_W-1:0] COIN_VALS = {8'd10, 8'd5, 8'd2, 8'd1},
`ifdef COIN_TOTAL_EN
    parameter int unsigned TOTAL_W    = 16,
`endif
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_COINS-1:0] coin_in,
    input  logic                 out_ready,
`ifdef COIN_TOTAL_EN
    input  logic                 total_clr,
    output logic [TOTAL_W-1:0]   credit_total,
`endif
    output logic                 out_valid,
    output logic [DATA_W-1:0]    data_out,
    output logic                 done,
    output logic                 coin_err,
    output logic                 overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Coin edge detection and classification
    // ------------------------------------------------------------------
    logic [NUM_COINS-1:0] coin_prev_q;
    logic [NUM_COINS-1:0] rise_c;
    logic                 onehot_c;
    logic                 accept_c;
    logic                 reject_c;
    logic [DATA_W-1:0]    coin_val_c;

    logic                 acc_vld_q;
    logic [DATA_W-1:0]    acc_val_q;
    logic                 coin_err_q;

    // Classify this cycle's edge: a clean single-line press is accepted, anything else rejected.
    always_comb begin
        rise_c     = coin_in & ~coin_prev_q;
        onehot_c   = (coin_in != '0) &&
                     ((coin_in & (coin_in - NUM_COINS'(1))) == '0);
        accept_c   = (rise_c != '0) && onehot_c && (rise_c == coin_in);
        reject_c   = (rise_c != '0) && !accept_c;
        coin_val_c = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (coin_in[i]) begin
                coin_val_c = coin_val_c | COIN_VALS[i*DATA_W +: DATA_W];
            end
        end
    end

    // Edge-sample register: previous coin lines, staged accept and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_prev_q <= '0;
            acc_vld_q   <= 1'b0;
            acc_val_q   <= '0;
            coin_err_q  <= 1'b0;
        end else begin
            coin_prev_q <= coin_in;
            acc_vld_q   <= accept_c;
            acc_val_q   <= accept_c ? coin_val_c : '0;
            coin_err_q  <= reject_c;
        end
    end

    // ------------------------------------------------------------------
    // Pending-coin FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full_c;
    logic              empty_c;
    logic              pop_c;
    logic              push_c;

    state_e            state_q, state_d;

    // Push/pop decisions; a pop in the same cycle frees the slot a full FIFO needs.
    always_comb begin
        full_c     = (count_q == CNT_W'(FIFO_DEPTH));
        empty_c    = (count_q == '0);
        pop_c      = (state_q == S_IDLE) && !empty_c;
        push_c     = acc_vld_q && (!full_c || pop_c);
        overflow_d = acc_vld_q && full_c && !pop_c;
        wr_ptr_d   = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d    = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= acc_val_q;
        end
    end

    // FIFO pointer, occupancy and overflow pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Output handshake FSM
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;

    // Next state, hold register and the output values that go with the next state.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = 1'b0;
        data_out_d  = '0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    hold_d  = mem_q[rd_ptr_q];
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_VALID) begin
            out_valid_d = 1'b1;
            data_out_d  = hold_d;
        end
        done_d = (state_d == S_DONE);
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
        end
    end

`ifdef COIN_TOTAL_EN
    // ------------------------------------------------------------------
    // Saturating credit accumulator
    // ------------------------------------------------------------------
    localparam int unsigned SUM_W = ((TOTAL_W > DATA_W) ? TOTAL_W : DATA_W) + 1;

    logic [TOTAL_W-1:0] credit_q, credit_d;
    logic [SUM_W-1:0]   credit_sum_c;

    // Only coins that actually enter the FIFO add credit; a clear restarts from that coin.
    always_comb begin
        credit_d     = credit_q;
        credit_sum_c = total_clr ? SUM_W'(acc_val_q)
                                 : (SUM_W'(credit_q) + SUM_W'(acc_val_q));
        if (push_c) begin
            if (credit_sum_c > SUM_W'({TOTAL_W{1'b1}})) begin
                credit_d = '1;
            end else begin
                credit_d = TOTAL_W'(credit_sum_c);
            end
        end else if (total_clr) begin
            credit_d = '0;
        end
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_total = credit_q;
`endif

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign coin_err  = coin_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_coin_accept_q.sv
// tb_coin_accept_q: directed and randomized bench for coin_accept_q against a
// queue-based behavioural model. Define COIN_TOTAL_EN to also check credit_total.
module tb_coin_accept_q;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned TB_TOTAL_W = 6;
    localparam int          CREDIT_MAX = (1 << TB_TOTAL_W) - 1;

    logic       clk;
    logic       rst;
    logic [3:0] coin_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] data_out;
    logic       done;
    logic       coin_err;
    logic       overflow;
`ifdef COIN_TOTAL_EN
    logic                  total_clr;
    logic [TB_TOTAL_W-1:0] credit_total;
`endif

    coin_accept_q #(
        .NUM_COINS (4),
        .DATA_W    (8),
        .COIN_VALS ({8'd10, 8'd5, 8'd2, 8'd1}),
`ifdef COIN_TOTAL_EN
        .TOTAL_W   (TB_TOTAL_W),
`endif
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_in     (coin_in),
        .out_ready   (out_ready),
`ifdef COIN_TOTAL_EN
        .total_clr   (total_clr),
        .credit_total(credit_total),
`endif
        .out_valid   (out_valid),
        .data_out    (data_out),
        .done        (done),
        .coin_err    (coin_err),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: coin denominations, pending queue, transfer phase, credit.
    int         coin_value [4] = '{1, 2, 5, 10};
    logic [3:0] m_prev;
    bit         m_staged;
    int         m_staged_val;
    int         m_queue [$];
    int         m_phase;      // 0 waiting, 1 presenting, 2 completion pulse
    int         m_hold;
    int         m_credit;
    bit         e_valid, e_done, e_err, e_ovf;
    int         e_data;

    int done_seen = 0;
    int ovf_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev       = '0;
        m_staged     = 1'b0;
        m_staged_val = 0;
        m_queue.delete();
        m_phase      = 0;
        m_hold       = 0;
        m_credit     = 0;
        e_valid = 0; e_done = 0; e_err = 0; e_ovf = 0; e_data = 0;
    endtask

    // Advance the model by one clock using the inputs that were presented at the edge.
    task automatic model_step(input logic [3:0] c, input logic r, input logic rs, input logic clr);
        logic [3:0] rise;
        bit         good, bad, took_head, pushed;
        int         val;
        if (rs) begin
            model_reset();
            return;
        end
        rise = c & ~m_prev;
        good = (rise != 0) && ($countones(c) == 1) && (rise == c);
        bad  = (rise != 0) && !good;
        val  = 0;
        for (int i = 0; i < 4; i++) if (c[i]) val = coin_value[i];

        took_head = 0;
        case (m_phase)
            0: if (m_queue.size() > 0) begin
                   m_hold    = m_queue.pop_front();
                   took_head = 1;
                   m_phase   = 1;
               end
            1: if (r) m_phase = 2;
            default: m_phase = 0;
        endcase

        e_ovf  = 0;
        pushed = 0;
        if (m_staged) begin
            if (m_queue.size() < DEPTH) begin
                m_queue.push_back(m_staged_val);
                pushed = 1;
            end else begin
                e_ovf = 1;
            end
        end
        if (clr)         m_credit = pushed ? m_staged_val : 0;
        else if (pushed) m_credit = m_credit + m_staged_val;
        if (m_credit > CREDIT_MAX) m_credit = CREDIT_MAX;

        m_staged     = good;
        m_staged_val = good ? val : 0;
        m_prev       = c;
        e_err        = bad;
        e_valid      = (m_phase == 1);
        e_data       = (m_phase == 1) ? m_hold : 0;
        e_done       = (m_phase == 2);
        if (took_head && m_phase != 1) e_valid = 0;
    endtask

    // Apply one cycle of inputs, then compare every output to the model.
    task automatic cyc(input logic [3:0] c, input logic r, input logic rs, input logic clr);
        coin_in   = c;
        out_ready = r;
        rst       = rs;
`ifdef COIN_TOTAL_EN
        total_clr = clr;
`endif
        @(posedge clk);
        model_step(c, r, rs, clr);
        #1;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("data_out",  32'(data_out),  32'(e_data));
        chk("done",      32'(done),      32'(e_done));
        chk("coin_err",  32'(coin_err),  32'(e_err));
        chk("overflow",  32'(overflow),  32'(e_ovf));
`ifdef COIN_TOTAL_EN
        chk("credit_total", 32'(credit_total), 32'(m_credit));
`endif
        if (done === 1'b1)     done_seen++;
        if (overflow === 1'b1) ovf_seen++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(4'b0000, r, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] c;
        logic [3:0] last_c;
        int         roll;

        model_reset();
        coin_in   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
`ifdef COIN_TOTAL_EN
        total_clr = 1'b0;
`endif

        // Reset state
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);

        // Held 5-unit coin: exactly one transfer
        done_seen = 0;
        for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);
        chk("t1_done_count", 32'(done_seen), 32'd1);

        // Pulses 1,2,10 with downstream always ready
        done_seen = 0;
        cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b1);
        chk("t2_done_count", 32'(done_seen), 32'd3);

        // Two lines rising together: rejected
        cyc(4'b0011, 1'b1, 1'b0, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Six coins with downstream stalled: one held, four buffered, one dropped
        ovf_seen  = 0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0001 << (i % 4), 1'b0, 1'b0, 1'b0);
            cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        end
        idle(3, 1'b0);
        idle(20, 1'b1);
        chk("t4_overflow_count", 32'(ovf_seen), 32'd1);
        chk("t4_done_count", 32'(done_seen), 32'd5);

        // Reset while presenting with coins still buffered; coin held through reset
        cyc(4'b0010, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b1, 1'b0);
        cyc(4'b1000, 1'b0, 1'b1, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1);
        chk("t5_done_count", 32'(done_seen), 32'd1);

`ifdef COIN_TOTAL_EN
        // Credit: 10+10+5, clear coinciding with a 2-unit coin, then saturation
        cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0); cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0); cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0100, 1'b1, 1'b0, 1'b0); cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);
        chk("t6_credit_25", 32'(credit_total), 32'd25);
        cyc(4'b0010, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("t6_credit_clr", 32'(credit_total), 32'd2);
        idle(4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1000, 1'b1, 1'b0, 1'b0);
            cyc(4'b0000, 1'b1, 1'b0, 1'b0);
            idle(2, 1'b1);
        end
        chk("t6_credit_sat", 32'(credit_total), 32'(CREDIT_MAX));
`endif

        // Randomized traffic
        last_c = '0;
        for (int n = 0; n < 400; n++) begin
            roll = $urandom_range(0, 99);
            if (roll < 55)      c = 4'b0000;
            else if (roll < 80) c = 4'b0001 << $urandom_range(0, 3);
            else if (roll < 92) c = last_c;
            else                c = 4'($urandom_range(0, 15));
            last_c = c;
            cyc(c, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 149) == 0),
                1'($urandom_range(0, 39) == 0));
        end
        idle(20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
